// File: rtl/up_loader.sv
// Program-load controller: halts the core, hunts the sync preamble, writes the image top-down.
// Optional trailing checksum byte enabled by defining UP_LOADER_CHECKSUM_EN.
module up_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter logic [7:0]  SYNC0  = 8'h55,
  parameter logic [7:0]  SYNC1  = 8'hAA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC_A,
    S_SYNC_B,
    S_LOAD,
`ifdef UP_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              loaded;
  logic              busy_nxt;

`ifdef UP_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_total;
  assign sum_total = sum + rx_data;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (prog) state_nxt = S_SYNC_A;
      S_SYNC_A: begin
        if (!prog) state_nxt = S_ERR;
        else if (rx_valid && rx_data == SYNC0) state_nxt = S_SYNC_B;
      end
      S_SYNC_B: begin
        if (!prog) state_nxt = S_ERR;
        else if (rx_valid) begin
          if (rx_data == SYNC1)      state_nxt = S_LOAD;
          else if (rx_data == SYNC0) state_nxt = S_SYNC_B;
          else                       state_nxt = S_SYNC_A;
        end
      end
      S_LOAD: begin
        if (!prog) state_nxt = S_ERR;
        else if (rx_valid && cnt == '0) begin
`ifdef UP_LOADER_CHECKSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef UP_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (!prog) state_nxt = S_ERR;
        else if (rx_valid) state_nxt = (sum_total == 8'h00) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:   if (!prog) state_nxt = S_IDLE;
      S_ERR:    if (prog) state_nxt = S_SYNC_A;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_nxt = (state_nxt == S_SYNC_A) || (state_nxt == S_SYNC_B) || (state_nxt == S_LOAD);
`ifdef UP_LOADER_CHECKSUM_EN
    if (state_nxt == S_CSUM) busy_nxt = 1'b1;
`endif
  end

  // Status outputs are computed from the next state so they are registered yet not lagging.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      loaded    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_hold <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef UP_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      state  <= state_nxt;
      mem_we <= 1'b0;

      if (state == S_SYNC_B && state_nxt == S_LOAD) begin
        cnt <= '1;
`ifdef UP_LOADER_CHECKSUM_EN
        sum <= '0;
`endif
      end

      // The counter holds at zero after the last write so it never wraps inside LOAD.
      if (state == S_LOAD && prog && rx_valid) begin
        mem_we    <= 1'b1;
        mem_addr  <= cnt;
        mem_wdata <= rx_data;
        if (cnt != '0) cnt <= cnt - 1'b1;
`ifdef UP_LOADER_CHECKSUM_EN
        sum <= sum_total;
`endif
      end

      if ((state == S_IDLE || state == S_ERR) && prog) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (state_nxt == S_DONE) begin
        done   <= 1'b1;
        loaded <= 1'b1;
      end
      if (state_nxt == S_ERR) err <= 1'b1;

      busy      <= busy_nxt;
      core_hold <= prog | busy_nxt | (state_nxt == S_ERR) | ~(loaded | (state_nxt == S_DONE));
    end
  end

endmodule

// File: tb/tb_up_loader.sv
// Self-checking bench for up_loader: write scoreboard plus preamble vector table and load sequences.
// Follows UP_LOADER_CHECKSUM_EN the same way the design does.
module tb_up_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       prog = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       core_hold;
  logic       busy;
  logic       done;
  logic       err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [15:0] sb[$];
  logic [7:0]  run_sum;

  up_loader #(.ADDR_W(8), .SYNC0(8'h55), .SYNC1(8'hAA)) dut (
    .clk(clk), .rst(rst), .prog(prog), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pre [6];
    int unsigned n;
    bit          load;
  } sync_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock; every write strobe seen is checked against the scoreboard.
  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    #1;
    if (mem_we === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          miscompares++;
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   mem_addr, mem_wdata, e[15:8], e[7:0]);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic start_prog();
    prog = 1'b1;
    tick();
    check("busy_rise", busy, 1);
  endtask

  task automatic send_data(input int n, input bit gap, input bit ones);
    logic [7:0] a, d;
    for (int i = 0; i < n; i++) begin
      a = 8'(255 - i);
      d = ones ? 8'h01 : a;
      sb.push_back({a, d});
      run_sum = run_sum + d;
      rx_data  = d;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      if (i == 0) check("we_latency", mem_we, 1);
      if (gap) tick();
    end
  endtask

  task automatic full_load(input bit gap);
    start_prog();
    run_sum = '0;
    send_byte(8'h55, gap);
    send_byte(8'hAA, gap);
    send_data(256, gap, 1'b0);
`ifdef UP_LOADER_CHECKSUM_EN
    send_byte(8'h00 - run_sum, gap);
`endif
    tick();
    check("load_done", done, 1);
    check("load_err", err, 0);
    check("load_busy", busy, 0);
    check("load_hold_prog", core_hold, 1);
    check("load_drain", sb.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_hold"}, core_hold, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  sync_vec_t vt[5];

  initial begin
    vt[0] = '{pre: '{8'h12, 8'h55, 8'h34, 8'h55, 8'h55, 8'hAA}, n: 6, load: 1'b1};
    vt[1] = '{pre: '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2, load: 1'b1};
    vt[2] = '{pre: '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00}, n: 2, load: 1'b0};
    vt[3] = '{pre: '{8'h55, 8'h55, 8'h55, 8'hAA, 8'h00, 8'h00}, n: 4, load: 1'b1};
    vt[4] = '{pre: '{8'h55, 8'h12, 8'hAA, 8'h00, 8'h00, 8'h00}, n: 3, load: 1'b0};

    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    check("idle_hold_unloaded", core_hold, 1);

    // Preamble hunt vectors: one data byte follows, written at 0xFF only if sync was found.
    for (int unsigned v = 0; v < 5; v++) begin
      start_prog();
      for (int unsigned k = 0; k < vt[v].n; k++) send_byte(vt[v].pre[k], 1'b0);
      if (vt[v].load) sb.push_back({8'hFF, 8'h42});
      send_byte(8'h42, 1'b0);
      prog = 1'b0;
      tick();
      tick();
      check("sync_err", err, 1);
      check("sync_hold", core_hold, 1);
      check("sync_drain", sb.size(), 0);
    end

    // Nominal load with idle gaps, then ignored byte in DONE and release timing.
    full_load(1'b1);
    send_byte(8'h77, 1'b0);
    tick();
    prog = 1'b0;
    check("hold_before_edge", core_hold, 1);
    tick();
    check("hold_release", core_hold, 0);
    check("done_kept", done, 1);
    tick();

    // Abort after 100 bytes; the 101st byte coincides with the prog fall and is dropped.
    start_prog();
    check("restart_done_clr", done, 0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_data(100, 1'b0, 1'b0);
    prog = 1'b0;
    send_byte(8'h9B, 1'b0);
    tick();
    check("abort_err", err, 1);
    check("abort_hold", core_hold, 1);
    check("abort_done", done, 0);
    check("abort_drain", sb.size(), 0);
    send_byte(8'h55, 1'b0);
    tick();

    // Full back-to-back reload recovers.
    full_load(1'b0);
    prog = 1'b0;
    tick();
    check("reload_hold", core_hold, 0);
    tick();

    // Reset mid-load.
    start_prog();
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_data(10, 1'b0, 1'b0);
    rst  = 1'b1;
    prog = 1'b0;
    tick();
    rst = 1'b0;
    check_reset_values("midrst");
    tick();
    tick();
    check("midrst_hold_idle", core_hold, 1);
    prog = 1'b1;
    tick();
    send_byte(8'h10, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h20, 1'b0);
    check("midrst_no_load", done, 0);
    prog = 1'b0;
    tick();
    tick();
    check("midrst_drain", sb.size(), 0);

`ifdef UP_LOADER_CHECKSUM_EN
    start_prog();
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_data(256, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0);
    tick();
    check("csum_ok_done", done, 1);
    check("csum_ok_err", err, 0);
    prog = 1'b0;
    tick();
    tick();
    start_prog();
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_data(256, 1'b0, 1'b1);
    send_byte(8'h01, 1'b0);
    tick();
    check("csum_bad_err", err, 1);
    check("csum_bad_done", done, 0);
    check("csum_bad_hold", core_hold, 1);
    prog = 1'b0;
    tick();
    check("csum_drain", sb.size(), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
